// File: rtl/mod_add_sequencer.sv
// rtl/mod_add_sequencer.sv - element-wise modular vector add sequencer around an external registered adder
//
// Streams len operand pairs from the operand memories through an external
// modular adder (one pair per cycle) and writes the corrected results to a
// result memory.
//
// Ports:
//   clk, reset        clock; asynchronous active-low reset
//   start, len,       start a vector operation of len coefficients modulo
//   modulus           modulus (accepted only when idle)
//   abort             cancel the operation in progress
//   busy, done        activity flag and one-cycle completion pulse
//   range_err         sticky flag: an operand was >= modulus
//   rd_en, rd_addr    operand memory read port (data returns next cycle)
//   rd_data_a/b       operand memory read data
//   add_a/b/m, add_c  external adder operands, modulus and registered result
//   wr_en, wr_addr,   result memory write port
//   wr_data
module mod_add_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   len,
    input  logic [DATA_WIDTH-1:0] modulus,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  range_err,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data_a,
    input  logic [DATA_WIDTH-1:0] rd_data_b,
    output logic [DATA_WIDTH-1:0] add_a,
    output logic [DATA_WIDTH-1:0] add_b,
    output logic [DATA_WIDTH-1:0] add_m,
    input  logic [DATA_WIDTH-1:0] add_c,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [DATA_WIDTH-1:0] mod_q, mod_d;
    // One bit wider than an address so len = 2**ADDR_WIDTH terminates correctly.
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                  drain_q, drain_d;
    logic                  v1_q, v1_d;      // read data valid this cycle
    logic                  v2_q, v2_d;      // adder result valid this cycle
    logic [ADDR_WIDTH-1:0] a1_q, a1_d;      // index of the read data
    logic [ADDR_WIDTH-1:0] a2_q, a2_d;      // index of the adder result
    logic                  rerr_q, rerr_d;
    logic                  oor;

    // Range check sits on the live read data so the flag shows in the same
    // cycle the offending operand is presented to the adder.
    assign oor = v1_q && ((rd_data_a >= mod_q) || (rd_data_b >= mod_q));

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        mod_d   = mod_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        v1_d    = 1'b0;
        v2_d    = v1_q;
        a1_d    = cnt_q[ADDR_WIDTH-1:0];
        a2_d    = a1_q;
        rerr_d  = rerr_q | oor;
        busy    = 1'b0;
        done    = 1'b0;
        rd_en   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d   = len;
                    mod_d   = modulus;
                    rerr_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = (len == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                busy  = 1'b1;
                rd_en = 1'b1;
                v1_d  = 1'b1;
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q + CNT_ONE == len_q) begin
                    state_d = DRAIN;
                    drain_d = 1'b0;
                end
            end
            DRAIN: begin
                busy    = 1'b1;
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Abort drops everything in flight; the result already at the write
        // port this cycle still lands, nothing after it does.
        if (abort && (state_q == RUN || state_q == DRAIN)) begin
            state_d = IDLE;
            v1_d    = 1'b0;
            v2_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            mod_q   <= '0;
            cnt_q   <= '0;
            drain_q <= 1'b0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            a1_q    <= '0;
            a2_q    <= '0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            mod_q   <= mod_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            a1_q    <= a1_d;
            a2_q    <= a2_d;
            rerr_q  <= rerr_d;
        end
    end

    assign rd_addr   = cnt_q[ADDR_WIDTH-1:0];
    assign add_a     = rd_data_a;
    assign add_b     = rd_data_b;
    assign add_m     = mod_q;
    assign range_err = rerr_q | oor;
    assign wr_en     = v2_q;
    assign wr_addr   = a2_q;
    // The adder only subtracts when a+b > m, so a sum of exactly m comes back
    // as m and is folded to zero here.
    assign wr_data   = !v2_q ? '0 : ((add_c == mod_q) ? '0 : add_c);

endmodule

// File: tb/tb_mod_add_sequencer.sv
// tb/tb_mod_add_sequencer.sv - scoreboard bench for mod_add_sequencer
module tb_mod_add_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic [4:0] len;
    logic [7:0] modulus;
    logic       abort;
    logic       busy, done, range_err, rd_en, wr_en;
    logic [3:0] rd_addr, wr_addr;
    logic [7:0] rd_data_a, rd_data_b, add_a, add_b, add_m, add_c, wr_data;

    mod_add_sequencer #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len), .modulus(modulus),
        .abort(abort), .busy(busy), .done(done), .range_err(range_err),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data_a(rd_data_a),
        .rd_data_b(rd_data_b), .add_a(add_a), .add_b(add_b), .add_m(add_m),
        .add_c(add_c), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    typedef struct {
        int addr;
        int data;
        int cyc;
    } exp_t;

    exp_t       q[$];
    exp_t       e;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] mem_a[16];
    logic [7:0] mem_b[16];
    int         exp_d[16];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Operand memories: one-cycle read latency.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data_a <= mem_a[rd_addr];
            rd_data_b <= mem_b[rd_addr];
        end
    end

    // External adder: registered, subtracts m only when a+b > m.
    always @(posedge clk) begin
        int s;
        s = int'(add_a) + int'(add_b);
        add_c <= 8'((s > int'(add_m)) ? s - int'(add_m) : s);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitor: every write must match the next queued expectation.
    always @(negedge clk) begin
        if (wr_en) begin
            if (q.size() == 0) begin
                chk("unexpected_write_addr", int'(wr_addr), -1);
            end else begin
                e = q.pop_front();
                chk("wr_addr", int'(wr_addr), e.addr);
                chk("wr_data", int'(wr_data), e.data);
                chk("wr_cycle", cyc, e.cyc);
            end
        end
    end

    // Runs one operation; rerr_off is the T0-relative cycle range_err first
    // rises (-1 = never). pokes issues ignored starts mid-run and in FIN.
    task automatic run_op(input int n, input int m, input int rerr_off, input bit pokes);
        int t0, nrd, nbusy, first, expaddr;
        bit got;
        @(negedge clk);
        len = 5'(n); modulus = 8'(m); start = 1'b1;
        @(posedge clk); #1;
        t0 = cyc; start = 1'b0;
        for (int k = 0; k < n; k++) q.push_back('{k, exp_d[k], t0 + k + 2});
        nrd = 0; nbusy = 0; first = -1; expaddr = 0; got = 0;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (pokes && cyc == t0 + 1) begin
                start = 1'b1; len = 5'd2; modulus = 8'd5;
            end
            if (rd_en) begin
                chk("rd_addr", int'(rd_addr), expaddr);
                expaddr++; nrd++;
            end
            if (busy) nbusy++;
            if (range_err && first < 0) first = cyc - t0;
            if (done) begin
                got = 1;
                chk("done_cycle", cyc - t0, (n == 0) ? 0 : n + 2);
            end
        end
        chk("done_seen", int'(got), 1);
        chk("rd_count", nrd, n);
        chk("busy_cycles", nbusy, (n == 0) ? 0 : n + 2);
        chk("range_err_first", first, rerr_off);
        chk("range_err_at_done", int'(range_err), int'(rerr_off >= 0));
        if (pokes) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            chk("start_in_fin_ignored", int'(busy), 0);
        end
    endtask

    initial begin
        int t0, cnt;
        reset = 1'b0; start = 1'b0; abort = 1'b0; len = '0; modulus = '0;
        repeat (2) @(negedge clk);
        chk("reset_ctrl", int'({busy, done, range_err, rd_en, wr_en}), 0);
        chk("reset_addr", int'({rd_addr, wr_addr}), 0);
        chk("reset_wr_data", int'(wr_data), 0);
        reset = 1'b1;

        // Basic vector, with ignored starts during RUN and FIN.
        mem_a[0:3] = '{8'd3, 8'd10, 8'd16, 8'd0};
        mem_b[0:3] = '{8'd5, 8'd8, 8'd1, 8'd0};
        exp_d[0:3] = '{8, 1, 0, 0};
        run_op(4, 17, -1, 1'b1);

        // a+b == m corner case.
        mem_a[0:1] = '{8'd9, 8'd16};
        mem_b[0:1] = '{8'd8, 8'd16};
        exp_d[0:1] = '{0, 15};
        run_op(2, 17, -1, 1'b0);

        // Zero-length vector.
        run_op(0, 17, -1, 1'b0);

        // Full-length vector: all 16 addresses, no wrap.
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = 8'(i * 10);
            mem_b[i] = 8'(i * 7 + 50);
            exp_d[i] = (i * 10 + i * 7 + 50) % 200;
        end
        run_op(16, 200, -1, 1'b0);

        // Out-of-range operand at index 1.
        mem_a[0:2] = '{8'd1, 8'd20, 8'd2};
        mem_b[0:2] = '{8'd1, 8'd1, 8'd2};
        exp_d[0:2] = '{2, 4, 4};
        run_op(3, 17, 2, 1'b0);

        // Next start clears range_err.
        mem_a[0:1] = '{8'd1, 8'd2};
        mem_b[0:1] = '{8'd3, 8'd4};
        exp_d[0:1] = '{4, 6};
        run_op(2, 17, -1, 1'b0);

        // Abort at T0+2 with len=8.
        for (int i = 0; i < 8; i++) begin
            mem_a[i] = 8'(i + 1);
            mem_b[i] = 8'd0;
        end
        @(negedge clk);
        len = 5'd8; modulus = 8'd17; start = 1'b1;
        @(posedge clk); #1;
        t0 = cyc; start = 1'b0;
        q.push_back('{0, 1, t0 + 2});
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_idle_busy", int'(busy), 0);
        chk("abort_idle_rd_en", int'(rd_en), 0);
        cnt = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done || rd_en || busy) cnt++;
        end
        chk("abort_quiet", cnt, 0);

        // Async reset mid-RUN with range_err already set.
        mem_a[0:1] = '{8'd2, 8'd20};
        @(negedge clk);
        len = 5'd8; modulus = 8'd17; start = 1'b1;
        @(posedge clk); #1;
        t0 = cyc; start = 1'b0;
        q.push_back('{0, 2, t0 + 2});
        q.push_back('{1, 3, t0 + 3});
        repeat (4) @(negedge clk);
        chk("pre_reset_range_err", int'(range_err), 1);
        #2 reset = 1'b0;
        #1;
        chk("async_reset_ctrl", int'({busy, done, range_err, rd_en, wr_en}), 0);
        chk("async_reset_data", int'({rd_addr, wr_addr, wr_data}), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (rd_en || busy || done || wr_en) cnt++;
        end
        chk("post_reset_quiet", cnt, 0);

        // Operation works normally after reset.
        mem_a[0:1] = '{8'd9, 8'd16};
        mem_b[0:1] = '{8'd8, 8'd16};
        exp_d[0:1] = '{0, 15};
        run_op(2, 17, -1, 1'b0);

        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
